// File: rtl/common_m00_axis.sv
// AXI4-Stream master: sends one NUMBER_OF_OUTPUT_WORDS-word packet per accepted start.
// Define COMMON_M00_AXIS_SNAPSHOT_EN to capture data_to_send on the accepting start edge.
module common_m00_axis #(
   parameter int C_M_AXIS_TDATA_WIDTH   = 8,
   parameter int NUMBER_OF_OUTPUT_WORDS = 128
) (
   input  logic                                               M_AXIS_ACLK,
   input  logic                                               M_AXIS_ARESET,
   input  logic [C_M_AXIS_TDATA_WIDTH*NUMBER_OF_OUTPUT_WORDS-1:0] data_to_send,
   input  logic                                               start,
   output logic                                               busy,
   output logic                                               send_done,
   output logic                                               M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]                    M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                  M_AXIS_TSTRB,
   output logic                                               M_AXIS_TLAST,
   input  logic                                               M_AXIS_TREADY
);

   localparam int W     = C_M_AXIS_TDATA_WIDTH;
   localparam int N     = NUMBER_OF_OUTPUT_WORDS;
   localparam int PTR_W = (N <= 2) ? 1 : $clog2(N);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] ptr, ptr_nxt;
   logic [W*N-1:0]   src;
   logic [W-1:0]     word;

`ifdef COMMON_M00_AXIS_SNAPSHOT_EN
   logic [W*N-1:0] snap;

   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         snap <= '0;
      end else if (state == IDLE && start) begin
         snap <= data_to_send;
      end
   end

   always_comb src = snap;
`else
   always_comb src = data_to_send;
`endif

   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Pointer holds on the last word so it never wraps inside a packet.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SEND;
               ptr_nxt   = '0;
            end
         end
         SEND: begin
            if (M_AXIS_TREADY) begin
               if (ptr == LAST_PTR) begin
                  state_nxt = DONE;
               end else begin
                  ptr_nxt = ptr + PTR_W'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (ptr == PTR_W'(i)) begin
            word = src[i*W +: W];
         end
      end
   end

   // Outputs decode registered state only; TREADY affects nothing until the next edge.
   always_comb begin
      M_AXIS_TVALID = (state == SEND);
      M_AXIS_TLAST  = (state == SEND) && (ptr == LAST_PTR);
      M_AXIS_TDATA  = (state == SEND) ? word : '0;
      M_AXIS_TSTRB  = '1;
      busy          = (state != IDLE);
      send_done     = (state == DONE);
   end

endmodule

// File: tb/tb_common_m00_axis.sv
// Scoreboard bench for common_m00_axis: a 4-word instance and a 1-word instance.
module tb_common_m00_axis;

   localparam int W = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, start, tready;
   logic [W*N-1:0]   data;
   logic             busy, done, tvalid, tlast;
   logic [W-1:0]     tdata;
   logic [W/8-1:0]   tstrb;

   logic             start1, tready1;
   logic [7:0]       data1;
   logic             busy1, done1, tvalid1, tlast1;
   logic [7:0]       tdata1;
   logic [0:0]       tstrb1;

   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_v, got_v;

   common_m00_axis #(.C_M_AXIS_TDATA_WIDTH(W), .NUMBER_OF_OUTPUT_WORDS(N)) dut (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .data_to_send(data), .start(start),
      .busy(busy), .send_done(done), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata),
      .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready)
   );

   common_m00_axis #(.C_M_AXIS_TDATA_WIDTH(8), .NUMBER_OF_OUTPUT_WORDS(1)) dut1 (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .data_to_send(data1), .start(start1),
      .busy(busy1), .send_done(done1), .M_AXIS_TVALID(tvalid1), .M_AXIS_TDATA(tdata1),
      .M_AXIS_TSTRB(tstrb1), .M_AXIS_TLAST(tlast1), .M_AXIS_TREADY(tready1)
   );

   task automatic push_packet(input logic [W*N-1:0] d);
      for (int i = 0; i < N; i++) begin
         logic [7:0] b;
         b = d[i*8 +: 8];
         exp_q.push_back({1'(i == N - 1), b});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tready = 1'b0; data = '0;
      start1 = 1'b0; tready1 = 1'b0; data1 = '0;
      repeat (3) @(negedge clk);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", tlast); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h want=00", tdata); end
      checks++; if (tstrb !== 1'b1) begin errors++; $display("FAIL reset_tstrb got=%b want=1", tstrb); end
      checks++; if (tvalid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_n1 got=%b%b want=00", tvalid1, busy1); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      data = 32'h44332211; tready = 1'b1; start = 1'b1;
      push_packet(data);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         checks++; if (tvalid !== 1'(c <= 4)) begin errors++; $display("FAIL basic_tvalid c=%0d got=%b want=%b", c, tvalid, 1'(c <= 4)); end
         checks++; if (done !== 1'(c == 5)) begin errors++; $display("FAIL basic_done c=%0d got=%b want=%b", c, done, 1'(c == 5)); end
         checks++; if (busy !== 1'(c <= 5)) begin errors++; $display("FAIL basic_busy c=%0d got=%b want=%b", c, busy, 1'(c <= 5)); end
         if (tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL basic_extra_beat got=%h want=none", tdata);
            end else begin
               exp_v = exp_q.pop_front(); got_v = {tlast, tdata};
               if (got_v !== exp_v) begin errors++; $display("FAIL basic_beat c=%0d got=%h want=%h", c, got_v, exp_v); end
            end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got=%0d left want=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_stall();
      int hs, done_cnt, k;
      logic stalled;
      logic [9:0] prev;
      hs = 0; done_cnt = 0; k = 0; stalled = 1'b0; prev = '0;
      data = 32'h44332211; start = 1'b1; tready = 1'b0;
      push_packet(data);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40 && done_cnt == 0; c++) begin
         tready = ((k % 4) == 0) || ((k % 4) == 3);
         k++;
         if (stalled) begin
            checks++;
            if ({tvalid, tlast, tdata} !== prev) begin errors++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, {tvalid, tlast, tdata}, prev); end
         end
         if (busy && !done) begin
            checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid_drop c=%0d got=%b want=1", c, tvalid); end
         end
         if (tvalid && tready) begin
            hs++; checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stall_extra_beat got=%h want=none", tdata);
            end else begin
               exp_v = exp_q.pop_front(); got_v = {tlast, tdata};
               if (got_v !== exp_v) begin errors++; $display("FAIL stall_beat c=%0d got=%h want=%h", c, got_v, exp_v); end
            end
         end
         stalled = tvalid && !tready;
         prev = {tvalid, tlast, tdata};
         if (done) done_cnt++;
         else @(negedge clk);
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_timeout got=%0d want=1", done_cnt); end
      checks++; if (hs != 4) begin errors++; $display("FAIL stall_handshakes got=%0d want=4", hs); end
      exp_q.delete();
      tready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int hs, done_cnt;
      hs = 0; done_cnt = 0;
      data = 32'h44332211; start = 1'b1; tready = 1'b1;
      push_packet(data);
      @(negedge clk);
      for (int c = 1; c <= 12; c++) begin
         start = (c == 2) || (c == 5);
         checks++; if (tvalid !== 1'(c <= 4)) begin errors++; $display("FAIL ign_tvalid c=%0d got=%b want=%b", c, tvalid, 1'(c <= 4)); end
         if (tvalid && tready) begin
            hs++; checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL ign_extra_beat got=%h want=none", tdata);
            end else begin
               exp_v = exp_q.pop_front(); got_v = {tlast, tdata};
               if (got_v !== exp_v) begin errors++; $display("FAIL ign_beat c=%0d got=%h want=%h", c, got_v, exp_v); end
            end
         end
         if (done) done_cnt++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (hs != 4) begin errors++; $display("FAIL ign_handshakes got=%0d want=4", hs); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
      exp_q.delete();
   endtask

   task automatic test_reset_abort();
      data = 32'h44332211; start = 1'b1; tready = 1'b1;
      push_packet(data);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         checks++;
         exp_v = exp_q.pop_front(); got_v = {tlast, tdata};
         if (tvalid !== 1'b1 || got_v !== exp_v) begin errors++; $display("FAIL abort_pre_beat c=%0d got=%b/%h want=1/%h", c, tvalid, got_v, exp_v); end
         @(negedge clk);
      end
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid got=%b want=0", tvalid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0 || tlast !== 1'b0) begin errors++; $display("FAIL abort_done_tlast got=%b%b want=00", done, tlast); end
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_quiet c=%0d got=%b%b%b want=000", c, tvalid, busy, done);
         end
      end
      start = 1'b1;
      push_packet(data);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         checks++; if (done !== 1'(c == 5)) begin errors++; $display("FAIL abort_fresh_done c=%0d got=%b want=%b", c, done, 1'(c == 5)); end
         if (tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL abort_fresh_extra got=%h want=none", tdata);
            end else begin
               exp_v = exp_q.pop_front(); got_v = {tlast, tdata};
               if (got_v !== exp_v) begin errors++; $display("FAIL abort_fresh_beat c=%0d got=%h want=%h", c, got_v, exp_v); end
            end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_fresh_missing got=%0d left want=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_single_word();
      data1 = 8'hA5; start1 = 1'b1; tready1 = 1'b0;
      exp_q.push_back({1'b1, 8'hA5});
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if ({tvalid1, tlast1, tdata1} !== {1'b1, 1'b1, 8'hA5}) begin errors++; $display("FAIL n1_first got=%b%b%h want=11a5", tvalid1, tlast1, tdata1); end
      @(negedge clk);
      tready1 = 1'b1;
      checks++;
      if (tvalid1 !== 1'b1) begin
         errors++; $display("FAIL n1_stall_tvalid got=%b want=1", tvalid1);
      end else begin
         exp_v = exp_q.pop_front(); got_v = {tlast1, tdata1};
         if (got_v !== exp_v) begin errors++; $display("FAIL n1_beat got=%h want=%h", got_v, exp_v); end
      end
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || tvalid1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL n1_done got=%b%b%b want=101", done1, tvalid1, busy1); end
      @(negedge clk);
      checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL n1_idle got=%b%b want=00", done1, busy1); end
      exp_q.delete();
   endtask

`ifdef COMMON_M00_AXIS_SNAPSHOT_EN
   task automatic test_snapshot();
      data = 32'h44332211; start = 1'b1; tready = 1'b1;
      push_packet(data);
      @(negedge clk);
      start = 1'b0;
      data = 32'hFFFFFFFF;
      for (int c = 1; c <= 5; c++) begin
         if (tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL snap_extra got=%h want=none", tdata);
            end else begin
               exp_v = exp_q.pop_front(); got_v = {tlast, tdata};
               if (got_v !== exp_v) begin errors++; $display("FAIL snap_beat c=%0d got=%h want=%h", c, got_v, exp_v); end
            end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL snap_missing got=%0d left want=0", exp_q.size()); end
      exp_q.delete();
      @(negedge clk);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_ignore_start();
      test_reset_abort();
      test_single_word();
`ifdef COMMON_M00_AXIS_SNAPSHOT_EN
      test_snapshot();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
